// File: rtl/cache_linefill.sv
// cache_linefill: critical-word-first 8-beat line fill that writes the assembled line to the cache RAM
//   nGCLK/RESET          clock, synchronous active-high reset
//   miss_req/miss_addr   miss request (taken only when idle) and missing byte address
//   busy                 fill or write in progress
//   mem_req/mem_addr     burst read request and current beat word address
//   mem_ack/mem_rdata    beat handshake and data
//   crit_valid/crit_data first returned word, forwarded combinationally
//   write_sel/write_port line index and 256-bit line for the RAM, held between writes
//   wr_ena/fill_done     one-cycle RAM write strobe and completion pulse
module cache_linefill #(
  parameter int LSS = 8,
  parameter int AW  = 32
) (
  input  logic           nGCLK,
  input  logic           RESET,
  input  logic           miss_req,
  input  logic [AW-1:0]  miss_addr,
  output logic           busy,
  output logic           mem_req,
  output logic [AW-1:0]  mem_addr,
  input  logic           mem_ack,
  input  logic [31:0]    mem_rdata,
  output logic           crit_valid,
  output logic [31:0]    crit_data,
  output logic [LSS-1:0] write_sel,
  output logic [255:0]   write_port,
  output logic           wr_ena,
  output logic           fill_done
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t         state_q, state_d;
  logic [AW-6:0]  tag_q, tag_d;
  logic [2:0]     start_q, start_d, beat_q, beat_d;
  logic [255:0]   buf_q, buf_d, port_q, port_d;
  logic [LSS-1:0] sel_q, sel_d;
  logic [31:0]    crit_q, crit_d;
  logic [2:0]     w;
  logic           ack;
  logic           unused;
  assign unused = ^miss_addr[1:0];
  assign w   = start_q + beat_q;
  assign ack = mem_ack && state_q == FILL;
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    start_d = start_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    port_d  = port_q;
    sel_d   = sel_q;
    crit_d  = crit_q;
    if (state_q == IDLE && miss_req) begin
      state_d = FILL;
      tag_d   = miss_addr[AW-1:5];
      start_d = miss_addr[4:2];
      beat_d  = '0;
    end
    if (ack) begin
      buf_d[{w, 5'b0} +: 32] = mem_rdata;
      beat_d = beat_q + 3'd1;
      crit_d = beat_q == 3'd0 ? mem_rdata : crit_q;
      // the RAM-facing copy is loaded with the final beat so it is valid during WRITE and held after
      if (beat_q == 3'd7) begin
        state_d = WRITE;
        port_d  = buf_d;
        sel_d   = tag_q[LSS-1:0];
      end
    end
    if (state_q == WRITE) state_d = IDLE;
  end
  always_ff @(posedge nGCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      tag_q   <= '0;
      start_q <= '0;
      beat_q  <= '0;
      buf_q   <= '0;
      port_q  <= '0;
      sel_q   <= '0;
      crit_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      start_q <= start_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      port_q  <= port_d;
      sel_q   <= sel_d;
      crit_q  <= crit_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign mem_req    = state_q == FILL;
  assign mem_addr   = mem_req ? {tag_q, w, 2'b00} : '0;
  assign crit_valid = ack && beat_q == 3'd0;
  assign crit_data  = crit_valid ? mem_rdata : crit_q;
  assign write_sel  = sel_q;
  assign write_port = port_q;
  assign wr_ena     = state_q == WRITE;
  assign fill_done  = wr_ena;
endmodule

// File: tb/tb_cache_linefill.sv
// tb_cache_linefill: randomized line-fill bench against a word-level model of the fill
module tb_cache_linefill;
  logic         nGCLK = 0;
  logic         RESET;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         busy, mem_req, mem_ack, crit_valid, wr_ena, fill_done;
  logic [31:0]  mem_addr, mem_rdata, crit_data;
  logic [7:0]   write_sel;
  logic [255:0] write_port;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [255:0] exp_port = '0;
  logic [7:0]   exp_sel = '0;
  logic [31:0]  exp_crit = '0;
  logic [10:0]  pat = 11'b10111011001;
  cache_linefill #(.LSS(8), .AW(32)) dut (
    .nGCLK(nGCLK), .RESET(RESET), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .crit_valid(crit_valid), .crit_data(crit_data),
    .write_sel(write_sel), .write_port(write_port), .wr_ena(wr_ena), .fill_done(fill_done)
  );
  always #5 nGCLK = ~nGCLK;
  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_crit_valid"}, crit_valid, 0);
    check({tag, "_crit_data"}, crit_data, 0);
    check({tag, "_write_sel"}, write_sel, 0);
    check({tag, "_write_port"}, write_port, 0);
    check({tag, "_wr_ena"}, wr_ena, 0);
    check({tag, "_fill_done"}, fill_done, 0);
  endtask
  // caller is positioned at a negedge; mode 0 = ack every cycle, 1 = fixed pattern, 2 = random acks
  task automatic fill(input logic [31:0] addr, input int mode, input bit seq_data, input bit hold,
                      input logic [31:0] addr2);
    logic [31:0] words [8];
    int b, cyc, st;
    bit a;
    logic [31:0] d;
    st = (addr >> 2) % 8;
    miss_req = 1;
    miss_addr = addr;
    check("idle_busy", busy, 0);
    @(posedge nGCLK);
    @(negedge nGCLK);
    miss_req = hold;
    miss_addr = hold ? addr2 : $urandom;
    b = 0;
    cyc = 0;
    while (b < 8 && cyc < 200) begin
      check("mem_req", mem_req, 1);
      check("busy", busy, 1);
      check("mem_addr", mem_addr, (addr & 32'hffff_ffe0) | (((st + b) % 8) << 2));
      a = mode == 0 ? 1'b1 : mode == 1 ? (cyc < 11 ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
      d = seq_data ? 32'h1000 + b : $urandom;
      mem_ack = a;
      mem_rdata = d;
      #1;
      check("crit_valid", crit_valid, a && b == 0);
      if (a && b == 0) begin
        check("crit_data", crit_data, d);
        exp_crit = d;
      end
      if (a) begin
        words[(st + b) % 8] = d;
        b++;
      end
      cyc++;
      @(negedge nGCLK);
    end
    if (b < 8) check("timeout_beats", b, 8);
    if (mode == 0) check("latency", cyc, 8);
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    for (int k = 0; k < 8; k++) exp_port[32*k +: 32] = words[k];
    exp_sel = 8'((addr >> 5) & 32'hff);
    #1;
    check("wr_ena", wr_ena, 1);
    check("fill_done", fill_done, 1);
    check("write_sel", write_sel, exp_sel);
    check("write_port", write_port, exp_port);
    check("wr_mem_req", mem_req, 0);
    check("wr_crit_valid", crit_valid, 0);
    @(negedge nGCLK);
    mem_ack = 0;
    check("post_wr_ena", wr_ena, 0);
    check("post_fill_done", fill_done, 0);
    check("post_busy", busy, 0);
    check("hold_write_port", write_port, exp_port);
    check("hold_write_sel", write_sel, exp_sel);
    check("hold_crit_data", crit_data, exp_crit);
  endtask
  initial begin
    logic [31:0] a2;
    RESET = 1;
    miss_req = 0;
    miss_addr = 0;
    mem_ack = 0;
    mem_rdata = 0;
    repeat (3) @(negedge nGCLK);
    RESET = 0;
    check_zero("reset");
    fill(32'h0000_1A40, 0, 1, 0, 0);
    check("linear_word0", exp_port[31:0], 32'h1000);
    fill(32'h0000_1A5C, 0, 1, 0, 0);
    check("wrap_word7", exp_port[255:224], 32'h1000);
    fill(32'h0000_3C88, 1, 0, 0, 0);
    a2 = 32'h0000_7E34;
    fill(32'h0000_5510, 0, 0, 1, a2);
    fill(a2, 2, 0, 0, 0);
    miss_req = 1;
    miss_addr = 32'h0000_9A6C;
    @(posedge nGCLK);
    @(negedge nGCLK);
    miss_req = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1;
      mem_rdata = $urandom;
      @(negedge nGCLK);
    end
    mem_ack = 0;
    RESET = 1;
    @(negedge nGCLK);
    RESET = 0;
    check_zero("midreset");
    exp_port = '0;
    for (int i = 0; i < 12; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      if (wr_ena || busy || crit_valid) check("midreset_quiet", {wr_ena, busy, crit_valid}, 0);
      @(negedge nGCLK);
    end
    mem_ack = 0;
    fill(32'h0000_9A6C, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1;
      mem_rdata = $urandom;
      #1;
      check("spur_crit_valid", crit_valid, 0);
      check("spur_mem_req", mem_req, 0);
      @(negedge nGCLK);
      check("spur_busy", busy, 0);
      check("spur_port", write_port, exp_port);
      check("spur_crit_data", crit_data, exp_crit);
    end
    mem_ack = 0;
    for (int i = 0; i < 20; i++) fill($urandom, 2, 0, $urandom_range(0, 1) == 1, $urandom);
    miss_req = 0;
    fill($urandom, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
